// File: rtl/iddr_delay_cal_if.sv
// Delay-line control and IDDR capture bundle between the calibrator
// (master) and the IDELAY/IDDR capture stage (slave).
interface iddr_delay_cal_if #(
    parameter int WIDTH = 1,
    parameter int TAP_W = 9
);
    logic             dly_rst;
    logic             dly_ce;
    logic             dly_inc;
    logic             dly_load;
    logic [TAP_W-1:0] dly_cnt_value;
    logic             dly_en_vtc;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;

    modport master (
        output dly_rst,
        output dly_ce,
        output dly_inc,
        output dly_load,
        output dly_cnt_value,
        output dly_en_vtc,
        input  q1,
        input  q2
    );

    modport slave (
        input  dly_rst,
        input  dly_ce,
        input  dly_inc,
        input  dly_load,
        input  dly_cnt_value,
        input  dly_en_vtc,
        output q1,
        output q2
    );
endinterface

// File: rtl/iddr_delay_cal.sv
// Input-delay calibration: sweep every tap against a training pattern,
// then park the delay at the centre of the longest error-free window.
module iddr_delay_cal #(
    parameter int WIDTH         = 1,
    parameter int TAP_W         = 9,
    parameter int MAX_TAP       = 511,
    parameter int VTC_WAIT      = 16,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 64,
    parameter int MIN_WINDOW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     pattern_q1,
    input  logic [WIDTH-1:0]     pattern_q2,
    iddr_delay_cal_if.master     dly,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [TAP_W-1:0]     center_tap,
    output logic [TAP_W:0]       window_len
);

    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] VTC_LAST    = CNT_W'(VTC_WAIT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] MAX_T       = TAP_W'(MAX_TAP);
    localparam logic [TAP_W:0]   MIN_W       = (TAP_W+1)'(MIN_WINDOW);

    typedef enum logic [3:0] {
        S_IDLE,
        S_VTC_OFF,
        S_TAP_RST,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_STEP,
        S_MOVE,
        S_FINISH
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TAP_W-1:0]   tap_q;
    logic               rst_q;
    logic               ce_q;
    logic               inc_q;
    logic               vtc_q;
    logic               busy_q;
    logic               done_q;
    logic               fail_q;
    logic               err_q;
    logic [TAP_W:0]     cur_len_q;
    logic [TAP_W-1:0]   cur_start_q;
    logic [TAP_W:0]     best_len_q;
    logic [TAP_W-1:0]   best_start_q;
    logic [TAP_W-1:0]   ctr_q;
    logic [TAP_W-1:0]   center_q;
    logic [TAP_W:0]     wlen_q;

    logic               mism;
    logic [TAP_W:0]     cur_len_d;
    logic [TAP_W-1:0]   cur_start_d;
    logic [TAP_W:0]     best_len_d;
    logic [TAP_W-1:0]   best_start_d;
    logic [TAP_W-1:0]   ctr_d;

    assign mism = |((dly.q1 ^ pattern_q1) | (dly.q2 ^ pattern_q2));

    // Window tracking for the tap just sampled; ties keep the earlier window.
    always_comb begin
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        if (!err_q) begin
            if (cur_len_q == '0) begin
                cur_start_d = tap_q;
            end
            cur_len_d = cur_len_q + 1'b1;
            if (cur_len_d > best_len_q) begin
                best_len_d   = cur_len_d;
                best_start_d = cur_start_d;
            end
        end else begin
            cur_len_d = '0;
        end
        ctr_d = best_start_d + TAP_W'((best_len_d - 1'b1) >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tap_q        <= '0;
            rst_q        <= 1'b0;
            ce_q         <= 1'b0;
            inc_q        <= 1'b0;
            vtc_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_q        <= 1'b0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            ctr_q        <= '0;
            center_q     <= '0;
            wlen_q       <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        err_q        <= 1'b0;
                        cur_len_q    <= '0;
                        cur_start_q  <= '0;
                        best_len_q   <= '0;
                        best_start_q <= '0;
                        ctr_q        <= '0;
                        center_q     <= '0;
                        wlen_q       <= '0;
                        cnt_q        <= '0;
                        vtc_q        <= 1'b0;
                        state_q      <= S_VTC_OFF;
                    end
                end
                S_VTC_OFF: begin
                    if (cnt_q == VTC_LAST) begin
                        cnt_q   <= '0;
                        rst_q   <= 1'b1;
                        state_q <= S_TAP_RST;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_TAP_RST: begin
                    rst_q   <= 1'b0;
                    tap_q   <= '0;
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    err_q <= err_q | mism;
                    if (cnt_q == SAMPLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_EVAL;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_EVAL: begin
                    cur_len_q    <= cur_len_d;
                    cur_start_q  <= cur_start_d;
                    best_len_q   <= best_len_d;
                    best_start_q <= best_start_d;
                    if (tap_q < MAX_T) begin
                        ce_q    <= 1'b1;
                        inc_q   <= 1'b1;
                        state_q <= S_STEP;
                    end else if (best_len_d >= MIN_W) begin
                        ctr_q   <= ctr_d;
                        state_q <= S_MOVE;
                    end else begin
                        ctr_q   <= '0;
                        rst_q   <= 1'b1;
                        state_q <= S_MOVE;
                    end
                end
                S_STEP: begin
                    ce_q    <= 1'b0;
                    inc_q   <= 1'b0;
                    tap_q   <= tap_q + 1'b1;
                    state_q <= S_SETTLE;
                end
                // Decrement pulses are separated by one idle cycle.
                S_MOVE: begin
                    if (rst_q) begin
                        rst_q  <= 1'b0;
                        tap_q  <= '0;
                        fail_q <= 1'b1;
                    end else if (ce_q) begin
                        ce_q  <= 1'b0;
                        tap_q <= tap_q - 1'b1;
                    end else if (tap_q == ctr_q) begin
                        cnt_q   <= '0;
                        state_q <= S_FINISH;
                    end else begin
                        ce_q  <= 1'b1;
                        inc_q <= 1'b0;
                    end
                end
                S_FINISH: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q    <= '0;
                        vtc_q    <= 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        center_q <= ctr_q;
                        wlen_q   <= best_len_q;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dly.dly_rst       = rst_q;
    assign dly.dly_ce        = ce_q;
    assign dly.dly_inc       = inc_q;
    assign dly.dly_load      = 1'b0;
    assign dly.dly_cnt_value = tap_q;
    assign dly.dly_en_vtc    = vtc_q;

    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign center_tap = center_q;
    assign window_len = wlen_q;

endmodule

// File: tb/tb_iddr_delay_cal.sv
// Bench for iddr_delay_cal: tap-tracking delay-line model, fixed window
// table, random windows against a window-search reference, reset/start corners.
module tb_iddr_delay_cal;

    localparam int W    = 2;
    localparam int TW   = 5;
    localparam int MAXT = 31;
    localparam int MINW = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  pat1  = '0;
    logic [W-1:0]  pat2  = '0;
    logic          busy;
    logic          done;
    logic          fail;
    logic [TW-1:0] center_tap;
    logic [TW:0]   window_len;

    iddr_delay_cal_if #(.WIDTH(W), .TAP_W(TW)) dif ();

    iddr_delay_cal #(
        .WIDTH(W), .TAP_W(TW), .MAX_TAP(MAXT), .VTC_WAIT(4),
        .SETTLE_CYCLES(4), .SAMPLE_CYCLES(8), .MIN_WINDOW(MINW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pattern_q1(pat1), .pattern_q2(pat2),
        .dly(dif),
        .busy(busy), .done(done), .fail(fail),
        .center_tap(center_tap), .window_len(window_len)
    );

    always #5 clk = ~clk;

    // Delay-line model: tap position, age since last tap change, pulse counts.
    logic [31:0] mask    = '0;
    int          inj_tap = -1;
    int          tap_m   = 0;
    int          age     = 0;
    int          decs    = 0;
    int          rsts    = 0;
    int          viol    = 0;
    logic        tap_ok;
    logic        inj;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_m <= 0;
            age   <= 0;
        end else if (dif.dly_rst) begin
            tap_m <= 0;
            age   <= 0;
            rsts  <= rsts + 1;
        end else if (dif.dly_ce) begin
            tap_m <= dif.dly_inc ? tap_m + 1 : tap_m - 1;
            age   <= 0;
            if (!dif.dly_inc) decs <= decs + 1;
        end else if (age < 100000) begin
            age <= age + 1;
        end
    end

    assign tap_ok = (tap_m >= 0 && tap_m <= MAXT) ? mask[tap_m[4:0]] : 1'b0;
    // Age 6 lies inside the sampling interval (4 settle + 8 sample cycles).
    assign inj    = (tap_m == inj_tap) && (age == 6);
    assign dif.q1 = (tap_ok ? pat1 : ~pat1) ^ W'(inj);
    assign dif.q2 = tap_ok ? pat2 : ~pat2;

    always @(negedge clk) begin
        pat1 <= W'($urandom);
        pat2 <= W'($urandom);
        if (!rst) begin
            if ((dif.dly_ce && dif.dly_rst) ||
                ((dif.dly_ce || dif.dly_rst) && dif.dly_en_vtc) ||
                dif.dly_load ||
                (tap_m != int'(dif.dly_cnt_value)))
                viol <= viol + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    // Reference: enumerate maximal runs of passing taps, keep first longest.
    function automatic void ref_cal(input logic [31:0] m, output int len,
                                    output int ctr, output bit fl);
        int bl;
        int bs;
        bl = 0;
        bs = 0;
        for (int s = 0; s <= MAXT; s++) begin
            if (m[s] && (s == 0 || !m[s-1])) begin
                int r;
                r = 0;
                while (s + r <= MAXT && m[s+r]) r++;
                if (r > bl) begin
                    bl = r;
                    bs = s;
                end
            end
        end
        len = bl;
        fl  = (bl < MINW);
        ctr = fl ? 0 : bs + (bl - 1) / 2;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " fail"}, fail, 0);
        chk({tag, " en_vtc"}, dif.dly_en_vtc, 1);
        chk({tag, " ce"}, dif.dly_ce, 0);
        chk({tag, " dly_rst"}, dif.dly_rst, 0);
        chk({tag, " cnt"}, dif.dly_cnt_value, 0);
        chk({tag, " center"}, center_tap, 0);
        chk({tag, " wlen"}, window_len, 0);
    endtask

    task automatic run_cal(input string tag, input logic [31:0] m,
                           input int itap, input int e_len, input int e_ctr,
                           input bit e_fail, input int e_dec,
                           input bit mid_start);
        int d0;
        int r0;
        int v0;
        bit got;
        mask    = m;
        inj_tap = itap;
        @(negedge clk);
        d0 = decs;
        r0 = rsts;
        v0 = viol;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_on"}, busy, 1);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (mid_start && i == 200) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end else begin
                @(negedge clk);
            end
            got = done;
        end
        chk({tag, " done_seen"}, got, 1);
        chk({tag, " fail"}, fail, e_fail);
        chk({tag, " wlen"}, window_len, e_len);
        chk({tag, " center"}, center_tap, e_ctr);
        chk({tag, " cnt"}, dif.dly_cnt_value, e_fail ? 0 : e_ctr);
        chk({tag, " en_vtc"}, dif.dly_en_vtc, 1);
        chk({tag, " busy_off"}, busy, 0);
        chk({tag, " dec_pulses"}, decs - d0, e_dec);
        chk({tag, " rst_pulses"}, rsts - r0, e_fail ? 2 : 1);
        chk({tag, " invariants"}, viol - v0, 0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] mask;
        int          inj;
        int          e_len;
        int          e_ctr;
        bit          e_fail;
        int          e_dec;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"single",  rng(10, 20),              -1, 11, 15, 0, 16};
        vecs[1] = '{"two_win", rng(2, 5) | rng(12, 19),  -1,  8, 15, 0, 16};
        vecs[2] = '{"tie",     rng(3, 8) | rng(20, 25),  -1,  6,  5, 0, 26};
        vecs[3] = '{"top",     rng(25, 31),              -1,  7, 28, 0,  3};
        vecs[4] = '{"all",     rng(0, 31),               -1, 32, 15, 0, 16};
        vecs[5] = '{"narrow",  rng(5, 6),                -1,  2,  0, 1,  0};
        vecs[6] = '{"glitch",  rng(10, 20),              12,  8, 16, 0, 15};
        vecs[7] = '{"empty",   32'h0,                    -1,  0,  0, 1,  0};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_cal(vecs[i].name, vecs[i].mask, vecs[i].inj, vecs[i].e_len,
                    vecs[i].e_ctr, vecs[i].e_fail, vecs[i].e_dec, 1'b0);

        run_cal("mid_start", rng(10, 20), -1, 11, 15, 0, 16, 1'b1);

        begin
            bit hit;
            mask    = rng(10, 20);
            inj_tap = -1;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            hit = 1'b0;
            for (int i = 0; i < 2000 && !hit; i++) begin
                @(negedge clk);
                hit = (tap_m == 5) && (age == 6);
            end
            chk("rst_mid reach_sample", hit, 1);
            rst = 1'b1;
            #1;
            chk_reset_vals("rst_mid");
            @(negedge clk);
            rst = 1'b0;
            run_cal("after_rst", rng(10, 20), -1, 11, 15, 0, 16, 1'b0);
        end

        for (int k = 0; k < 12; k++) begin
            logic [31:0] m;
            logic [31:0] mref;
            int          itap;
            int          e_len;
            int          e_ctr;
            bit          e_fl;
            m = '0;
            for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
                int lo;
                int hi;
                lo = int'($urandom_range(0, MAXT));
                hi = lo + int'($urandom_range(0, 11));
                if (hi > MAXT) hi = MAXT;
                m = m | rng(lo, hi);
            end
            itap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAXT)) : -1;
            mref = m;
            if (itap >= 0) mref[itap] = 1'b0;
            ref_cal(mref, e_len, e_ctr, e_fl);
            run_cal($sformatf("rand%0d", k), m, itap, e_len, e_ctr, e_fl,
                    e_fl ? 0 : MAXT - e_ctr, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/iddr_delay_cal.md
Name: iddr_delay_cal

Overview:
- Input-delay calibration controller that sits directly upstream of the IDDR/IDELAY capture stage.
- It drives the shared delay-line controls: reset, CE, INC, LOAD, count value and VT-compensation enable.
- It observes the captured q1/q2 outputs while the link partner sends a known training pattern.
- It sweeps all taps, finds the longest contiguous error-free window, then parks the delay at the window centre and re-enables VT compensation.

Parameters:
- WIDTH, 1: number of data lanes; all lanes share one set of delay controls.
- TAP_W, 9: width of the tap count.
- MAX_TAP, 511: last tap swept; must be ≤ 2^TAP_W−1.
- VTC_WAIT, 16: cycles to wait after deasserting dly_en_vtc before the first tap change.
- SETTLE_CYCLES, 16: cycles after any tap change before sampling starts.
- SAMPLE_CYCLES, 64: compare cycles per tap.
- MIN_WINDOW, 8: minimum passing window length for success.

Ports:
- clk  in  1  clock for the block and the delay-line control interface.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins calibration; ignored while busy.
- pattern_q1  in  WIDTH  expected q1 value during training.
- pattern_q2  in  WIDTH  expected q2 value during training.
- q1  in  WIDTH  rising-edge capture from the IDDR stage.
- q2  in  WIDTH  falling-edge capture from the IDDR stage.
- dly_rst  out  1  one-cycle pulse that returns the delay to tap 0.
- dly_ce  out  1  one-cycle step enable.
- dly_inc  out  1  step direction: 1 = increment, 0 = decrement; only meaningful with dly_ce.
- dly_load  out  1  held at 0; VARIABLE mode is used.
- dly_cnt_value  out  TAP_W  current tap as tracked by the controller.
- dly_en_vtc  out  1  VT-compensation enable.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  sticky; cleared by an accepted start.
- fail  out  1  sticky; valid when done=1.
- center_tap  out  TAP_W  final tap selected.
- window_len  out  TAP_W+1  length of the best window found.

Behaviour:
- Reset values: dly_en_vtc=1; every other output 0; FSM in IDLE.
- Reset is honoured mid-operation; the next start performs a full calibration.
- FSM states: IDLE → VTC_OFF → TAP_RST → SETTLE → SAMPLE → EVAL → (STEP → SETTLE | MOVE | FINISH).
- IDLE: start=1 clears done, fail, window registers and tracking state; sets busy; goes to VTC_OFF.
- VTC_OFF: dly_en_vtc=0; wait VTC_WAIT cycles.
- TAP_RST: dly_rst=1 for exactly one cycle; tap=0.
- SETTLE: wait SETTLE_CYCLES cycles.
- SAMPLE: for SAMPLE_CYCLES cycles, compare q1/q2 of every lane against the patterns. Any mismatch in any cycle or lane marks the tap failed.
- EVAL (one cycle):
  - On pass: if cur_len=0, set cur_start=tap; cur_len++.
  - If the new cur_len > best_len (strict, so on ties the first window is kept): best_start=cur_start, best_len=cur_len.
  - On fail: cur_len=0.
  - If tap<MAX_TAP go to STEP. Otherwise compute center = best_start + ((best_len−1)>>1) (floor) and go to MOVE.
- STEP: dly_ce=1, dly_inc=1 for one cycle; tap++; go to SETTLE.
- MOVE, success path (best_len ≥ MIN_WINDOW):
  - Issue (MAX_TAP−center) decrement pulses: dly_ce=1, dly_inc=0, each followed by one idle cycle; tap-- per pulse.
  - If center=MAX_TAP, issue zero pulses.
- MOVE, fail path (best_len < MIN_WINDOW, including 0): one dly_rst pulse, tap=0, fail=1, center_tap=0.
- FINISH: wait SETTLE_CYCLES, then dly_en_vtc=1, set done, clear busy, latch center_tap and window_len; return to IDLE.
- dly_cnt_value always equals the delay line's tap as driven by this block's pulses.
- Sweep arithmetic: tap never wraps; the last evaluated tap is MAX_TAP. best_len saturates at MAX_TAP+1.
- dly_ce and dly_rst never assert while dly_en_vtc=1, and never assert in the same cycle.

Test Plan:
- Config for all scenarios: MAX_TAP=31, VTC_WAIT=4, SETTLE=4, SAMPLE=8, MIN_WINDOW=4. The delay model returns the correct pattern only for passing taps.
- Single window, taps 10..20 pass → done=1, fail=0, window_len=11, center_tap=15; exactly 16 decrement pulses after the sweep; dly_en_vtc back to 1.
- Two windows, 2..5 and 12..19 → window_len=8, center_tap=15. Tie, 3..8 and 20..25 → center_tap=5 (first window kept).
- Window at the top, 25..31 → window_len=7, center_tap=28, 3 decrement pulses. Window at 0..31 → center_tap=15.
- Narrow window 5..6 → fail=1, done=1, center_tap=0, dly_rst pulsed, dly_cnt_value=0.
- Behaviour under disturbance:
  - A single-cycle, single-lane mismatch inside tap 12 of window 10..20 → window 13..20, center_tap=16.
  - start pulsed mid-sweep → ignored.
  - rst asserted mid-SAMPLE → all outputs return to reset values immediately; a following start completes normally.
